// File: rtl/gelato_fetch_scheduler.sv
// Per-warp PC table with a round-robin fetch scheduler feeding the fetch stage.
// Optional performance counters are enabled by defining GELATO_FETCH_SKD_PERF_EN.
module gelato_fetch_scheduler #(
    parameter int unsigned NUM_WARPS = 8,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned WARP_W    = $clog2(NUM_WARPS),
    parameter int unsigned SPLIT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 launch_valid,
    input  logic [WARP_W-1:0]    launch_warp,
    input  logic [PC_WIDTH-1:0]  launch_pc,
    input  logic [SPLIT_W-1:0]   launch_split,
    output logic                 launch_err,
    input  logic [NUM_WARPS-1:0] ibuf_full,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [PC_WIDTH-1:0]  fetch_pc,
    output logic [WARP_W-1:0]    fetch_warp_num,
    output logic [SPLIT_W-1:0]   fetch_split_table_num,
    input  logic                 commit_valid,
    input  logic [WARP_W-1:0]    commit_warp,
    input  logic [PC_WIDTH-1:0]  commit_next_pc,
    input  logic [SPLIT_W-1:0]   commit_split,
    input  logic                 commit_exit,
    output logic [NUM_WARPS-1:0] warp_active,
    output logic                 all_idle
`ifdef GELATO_FETCH_SKD_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    logic [NUM_WARPS-1:0] active_q, active_d;
    logic [NUM_WARPS-1:0] inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
    logic [SPLIT_W-1:0]   split_q [NUM_WARPS];
    logic [SPLIT_W-1:0]   split_d [NUM_WARPS];
    logic [WARP_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [WARP_W-1:0]    fetch_warp_q, fetch_warp_d;
    logic [SPLIT_W-1:0]   fetch_split_q, fetch_split_d;
    logic                 launch_err_q, launch_err_d;

    logic [NUM_WARPS-1:0] eligible;
    logic                 sel_found;
    logic [WARP_W-1:0]    sel_idx;
    logic [WARP_W-1:0]    cand;

    assign eligible = active_q & ~inflight_q & ~ibuf_full;

    // Round-robin pick: first eligible warp starting at rr_ptr, from registered state only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            cand = rr_ptr_q + WARP_W'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state: launch, commit, and output-register handshake; everything holds when rdy=0.
    always_comb begin
        active_d      = active_q;
        inflight_d    = inflight_q;
        pc_d          = pc_q;
        split_d       = split_q;
        rr_ptr_d      = rr_ptr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_warp_d  = fetch_warp_q;
        fetch_split_d = fetch_split_q;
        launch_err_d  = launch_err_q;
        if (rdy) begin
            launch_err_d = 1'b0;
            // Commit is a no-op unless the warp is inflight (which implies active).
            if (commit_valid && inflight_q[commit_warp]) begin
                pc_d[commit_warp]       = commit_next_pc;
                split_d[commit_warp]    = commit_split;
                inflight_d[commit_warp] = 1'b0;
                if (commit_exit) begin
                    active_d[commit_warp] = 1'b0;
                end
            end
            // Judged against pre-commit state, so a same-warp commit still flags the launch.
            if (launch_valid) begin
                if (active_q[launch_warp]) begin
                    launch_err_d = 1'b1;
                end else begin
                    active_d[launch_warp]   = 1'b1;
                    inflight_d[launch_warp] = 1'b0;
                    pc_d[launch_warp]       = launch_pc;
                    split_d[launch_warp]    = launch_split;
                end
            end
            if (fetch_valid_q) begin
                if (fetch_ready) begin
                    fetch_valid_d            = 1'b0;
                    inflight_d[fetch_warp_q] = 1'b1;
                    rr_ptr_d                 = fetch_warp_q + WARP_W'(1);
                end
            end else if (sel_found) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = pc_q[sel_idx];
                fetch_warp_d  = sel_idx;
                fetch_split_d = split_q[sel_idx];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            inflight_q    <= '0;
            pc_q          <= '{default: '0};
            split_q       <= '{default: '0};
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_warp_q  <= '0;
            fetch_split_q <= '0;
            launch_err_q  <= 1'b0;
        end else begin
            active_q      <= active_d;
            inflight_q    <= inflight_d;
            pc_q          <= pc_d;
            split_q       <= split_d;
            rr_ptr_q      <= rr_ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_warp_q  <= fetch_warp_d;
            fetch_split_q <= fetch_split_d;
            launch_err_q  <= launch_err_d;
        end
    end

    assign launch_err            = launch_err_q;
    assign fetch_valid           = fetch_valid_q;
    assign fetch_pc              = fetch_pc_q;
    assign fetch_warp_num        = fetch_warp_q;
    assign fetch_split_table_num = fetch_split_q;
    assign warp_active           = active_q;
    assign all_idle              = ~|active_q & ~fetch_valid_q;

`ifdef GELATO_FETCH_SKD_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    // Saturating counters of accepted requests and back-pressured cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else if (rdy && fetch_valid_q) begin
            if (fetch_ready) begin
                if (perf_issued_q != '1) perf_issued_q <= perf_issued_q + 32'd1;
            end else begin
                if (perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed self-checking bench for gelato_fetch_scheduler (default parameters).
module tb_gelato_fetch_scheduler;

    localparam int unsigned NW = 8;

    logic        clk, rst_n, rdy;
    logic        launch_valid;
    logic [2:0]  launch_warp;
    logic [31:0] launch_pc;
    logic [3:0]  launch_split;
    logic        launch_err;
    logic [7:0]  ibuf_full;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic [2:0]  fetch_warp_num;
    logic [3:0]  fetch_split_table_num;
    logic        commit_valid;
    logic [2:0]  commit_warp;
    logic [31:0] commit_next_pc;
    logic [3:0]  commit_split;
    logic        commit_exit;
    logic [7:0]  warp_active;
    logic        all_idle;
`ifdef GELATO_FETCH_SKD_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int vectors;
    int miscompares;

    gelato_fetch_scheduler #(
        .NUM_WARPS(NW),
        .PC_WIDTH (32),
        .SPLIT_W  (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rdy                  (rdy),
        .launch_valid         (launch_valid),
        .launch_warp          (launch_warp),
        .launch_pc            (launch_pc),
        .launch_split         (launch_split),
        .launch_err           (launch_err),
        .ibuf_full            (ibuf_full),
        .fetch_valid          (fetch_valid),
        .fetch_ready          (fetch_ready),
        .fetch_pc             (fetch_pc),
        .fetch_warp_num       (fetch_warp_num),
        .fetch_split_table_num(fetch_split_table_num),
        .commit_valid         (commit_valid),
        .commit_warp          (commit_warp),
        .commit_next_pc       (commit_next_pc),
        .commit_split         (commit_split),
        .commit_exit          (commit_exit),
        .warp_active          (warp_active),
        .all_idle             (all_idle)
`ifdef GELATO_FETCH_SKD_PERF_EN
        ,
        .perf_issued          (perf_issued),
        .perf_stall           (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] w, input logic [31:0] pc, input logic [3:0] sp);
        launch_valid = 1'b1;
        launch_warp  = w;
        launch_pc    = pc;
        launch_split = sp;
        step();
        launch_valid = 1'b0;
    endtask

    task automatic commit(input logic [2:0] w, input logic [31:0] npc, input logic [3:0] sp,
                          input logic ex);
        commit_valid   = 1'b1;
        commit_warp    = w;
        commit_next_pc = npc;
        commit_split   = sp;
        commit_exit    = ex;
        step();
        commit_valid   = 1'b0;
        commit_exit    = 1'b0;
    endtask

    // Wait (bounded) for a request, check its payload, accept it, then commit that warp.
    task automatic issue_commit(input logic [2:0] ew, input logic [31:0] epc, input logic [3:0] esp,
                                input logic [31:0] npc, input logic [3:0] nsp, input logic ex);
        int n = 0;
        while (!fetch_valid && n < 8) begin
            step();
            n++;
        end
        chk("issue_valid", 64'(fetch_valid), 64'd1);
        chk("issue_warp", 64'(fetch_warp_num), 64'(ew));
        chk("issue_pc", 64'(fetch_pc), 64'(epc));
        chk("issue_split", 64'(fetch_split_table_num), 64'(esp));
        fetch_ready = 1'b1;
        step();
        chk("accept_drop", 64'(fetch_valid), 64'd0);
        commit(ew, npc, nsp, ex);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; rdy = 1'b1;
        launch_valid = 1'b0; launch_warp = '0; launch_pc = '0; launch_split = '0;
        ibuf_full = '0; fetch_ready = 1'b0;
        commit_valid = 1'b0; commit_warp = '0; commit_next_pc = '0; commit_split = '0;
        commit_exit = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_pc", 64'(fetch_pc), 64'd0);
        chk("rst_warp", 64'(fetch_warp_num), 64'd0);
        chk("rst_split", 64'(fetch_split_table_num), 64'd0);
        chk("rst_err", 64'(launch_err), 64'd0);
        chk("rst_idle", 64'(all_idle), 64'd1);
        chk("rst_active", 64'(warp_active), 64'd0);
        rst_n = 1'b1;
        step();

        // Single warp: request appears two edges after launch, then nothing more.
        fetch_ready = 1'b1;
        launch(3'd3, 32'h100, 4'd2);
        chk("t1_valid_early", 64'(fetch_valid), 64'd0);
        chk("t1_active", 64'(warp_active), 64'h08);
        chk("t1_not_idle", 64'(all_idle), 64'd0);
        step();
        chk("t1_valid", 64'(fetch_valid), 64'd1);
        chk("t1_pc", 64'(fetch_pc), 64'h100);
        chk("t1_warp", 64'(fetch_warp_num), 64'd3);
        chk("t1_split", 64'(fetch_split_table_num), 64'd2);
        step();
        chk("t1_accept", 64'(fetch_valid), 64'd0);
        step(); step(); step();
        chk("t1_inflight_quiet", 64'(fetch_valid), 64'd0);
        commit(3'd3, 32'h104, 4'd0, 1'b1);
        chk("t1_exit_active", 64'(warp_active), 64'd0);
        chk("t1_exit_idle", 64'(all_idle), 64'd1);

        // Three warps round-robin with PCs advancing by 4.
        fetch_ready = 1'b0;
        launch(3'd0, 32'h00, 4'd0);
        launch(3'd1, 32'h40, 4'd0);
        launch(3'd2, 32'h80, 4'd0);
        chk("t2_active", 64'(warp_active), 64'h07);
        issue_commit(3'd0, 32'h00, 4'd0, 32'h04, 4'd1, 1'b0);
        issue_commit(3'd1, 32'h40, 4'd0, 32'h44, 4'd1, 1'b0);
        issue_commit(3'd2, 32'h80, 4'd0, 32'h84, 4'd1, 1'b0);
        issue_commit(3'd0, 32'h04, 4'd1, 32'h08, 4'd2, 1'b0);
        issue_commit(3'd1, 32'h44, 4'd1, 32'h48, 4'd2, 1'b0);
        issue_commit(3'd2, 32'h84, 4'd1, 32'h88, 4'd2, 1'b0);

        // Exits drain every warp.
        issue_commit(3'd0, 32'h08, 4'd2, 32'h0, 4'd0, 1'b1);
        chk("t4_active_a", 64'(warp_active), 64'h06);
        issue_commit(3'd1, 32'h48, 4'd2, 32'h0, 4'd0, 1'b1);
        chk("t4_active_b", 64'(warp_active), 64'h04);
        issue_commit(3'd2, 32'h88, 4'd2, 32'h0, 4'd0, 1'b1);
        chk("t4_active_c", 64'(warp_active), 64'h00);
        chk("t4_idle", 64'(all_idle), 64'd1);

        // Back-pressure: payload stable, ibuf_full rising does not retract.
        fetch_ready = 1'b0;
        launch(3'd5, 32'h500, 4'd3);
        step();
        chk("t3_valid", 64'(fetch_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ibuf_full = 8'h20;
            step();
            chk("t3_hold_valid", 64'(fetch_valid), 64'd1);
            chk("t3_hold_pc", 64'(fetch_pc), 64'h500);
            chk("t3_hold_warp", 64'(fetch_warp_num), 64'd5);
            chk("t3_hold_split", 64'(fetch_split_table_num), 64'd3);
        end
        fetch_ready = 1'b1;
        step();
        chk("t3_accept", 64'(fetch_valid), 64'd0);
        ibuf_full = '0;

        // rdy=0: commit and launch ignored, nothing moves.
        rdy = 1'b0;
        commit_valid = 1'b1; commit_warp = 3'd5; commit_next_pc = 32'h5F0;
        commit_split = 4'd9; commit_exit = 1'b0;
        launch_valid = 1'b1; launch_warp = 3'd6; launch_pc = 32'h600; launch_split = 4'd1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_frz_active", 64'(warp_active), 64'h20);
            chk("t6_frz_valid", 64'(fetch_valid), 64'd0);
        end
        rdy = 1'b1;
        commit_valid = 1'b0;
        launch_valid = 1'b0;
        step(); step();
        chk("t6_still_inflight", 64'(fetch_valid), 64'd0);
        commit(3'd5, 32'h504, 4'd3, 1'b0);
        step();
        chk("t6_refetch_valid", 64'(fetch_valid), 64'd1);
        chk("t6_refetch_pc", 64'(fetch_pc), 64'h504);
        rdy = 1'b0;
        commit_valid = 1'b1; commit_warp = 3'd5; commit_next_pc = 32'h777; commit_exit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_frz_req_valid", 64'(fetch_valid), 64'd1);
            chk("t6_frz_req_pc", 64'(fetch_pc), 64'h504);
        end
        commit_valid = 1'b0; commit_exit = 1'b0;
        rdy = 1'b1;
        step();
        chk("t6_accept", 64'(fetch_valid), 64'd0);
        commit(3'd5, 32'h0, 4'd0, 1'b1);
        chk("t6_exit", 64'(warp_active), 64'h00);

        // Launch collides with commit on an active warp.
        launch(3'd2, 32'h20, 4'd0);
        step();
        chk("t5_valid", 64'(fetch_valid), 64'd1);
        chk("t5_pc", 64'(fetch_pc), 64'h20);
        step();
        fetch_ready = 1'b0;
        launch_valid = 1'b1; launch_warp = 3'd2; launch_pc = 32'h999; launch_split = 4'd1;
        commit(3'd2, 32'h200, 4'd7, 1'b0);
        launch_valid = 1'b0;
        chk("t5_err", 64'(launch_err), 64'd1);
        chk("t5_active", 64'(warp_active), 64'h04);
        step();
        chk("t5_err_pulse", 64'(launch_err), 64'd0);
        chk("t5_fetch_valid", 64'(fetch_valid), 64'd1);
        chk("t5_fetch_pc", 64'(fetch_pc), 64'h200);
        chk("t5_fetch_split", 64'(fetch_split_table_num), 64'd7);

        // Reset mid-request clears everything immediately.
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", 64'(fetch_valid), 64'd0);
        chk("rst2_active", 64'(warp_active), 64'd0);
        chk("rst2_idle", 64'(all_idle), 64'd1);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("rst2_quiet", 64'(fetch_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
- Per-warp PC table and round-robin fetch scheduler; sits directly upstream of the instruction fetch stage.
- Holds PC, split-table index and status for every warp.
- Picks one eligible warp per issue and presents {pc, warp_num, split_table_num} on a valid/ready handshake to the fetch stage.
- Receives launch requests from the warp dispatcher and next-PC/exit commits from decode/branch resolution.

Parameters:
- NUM_WARPS, 8, number of hardware warps (power of two, >=2)
- PC_WIDTH, 32, PC width in bits
- WARP_W, $clog2(NUM_WARPS), warp index width
- SPLIT_W, 4, split-table index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; 0 freezes all state and handshakes
- launch_valid  in  1  start a warp
- launch_warp  in  WARP_W  warp to start
- launch_pc  in  PC_WIDTH  start PC
- launch_split  in  SPLIT_W  initial split-table index
- launch_err  out  1  pulse: launch targeted an already-active warp
- ibuf_full  in  NUM_WARPS  per-warp instruction-buffer full; masks eligibility
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  fetch stage accepts
- fetch_pc  out  PC_WIDTH  PC of issued warp
- fetch_warp_num  out  WARP_W  issued warp
- fetch_split_table_num  out  SPLIT_W  split-table index of issued warp
- commit_valid  in  1  fetched instruction resolved
- commit_warp  in  WARP_W  warp resolved
- commit_next_pc  in  PC_WIDTH  next PC (pc+4 or branch target)
- commit_split  in  SPLIT_W  updated split-table index
- commit_exit  in  1  warp terminated
- warp_active  out  NUM_WARPS  per-warp active flags
- all_idle  out  1  no warp active and fetch_valid=0

Behaviour:
- Reset (async):
  - All warps inactive, inflight=0, PCs=0, rr_ptr=0.
  - fetch_valid=0; fetch_pc, fetch_warp_num and fetch_split_table_num=0.
  - launch_err=0; all_idle=1.
- rdy=0: no register changes; outputs hold; launch/commit inputs ignored that cycle.
- Per-warp state: INACTIVE -> (launch) READY -> (issue accepted) INFLIGHT -> (commit, exit=0) READY | (commit, exit=1) INACTIVE.
- Eligible = active & !inflight & !ibuf_full[w].
- Selection:
  - Round-robin: first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_WARPS.
  - Computed from registered state only.
- Output register:
  - When fetch_valid=0 and an eligible warp exists, load outputs and set fetch_valid=1 at the next edge. Latency is 1 cycle from eligibility.
  - fetch_valid and all payload are held stable until fetch_ready=1 (no retraction, even if ibuf_full rises).
  - On accept (fetch_valid & fetch_ready): the selected warp becomes INFLIGHT, rr_ptr = warp+1 (wraps to 0).
  - fetch_valid drops to 0 for one cycle: at most one request every 2 cycles.
- Launch:
  - If the target is INACTIVE: PC/split are loaded and the warp becomes READY next edge.
  - If the target is active: ignored, launch_err=1 for exactly one cycle.
- Commit:
  - PC <= commit_next_pc, split <= commit_split, inflight cleared.
  - exit=1 clears active.
  - A commit to a non-inflight warp is ignored.
- Simultaneous events:
  - Launch and commit to the same warp: commit applied, launch treated as to an active warp (launch_err=1).
  - Commit and accept in the same cycle to different warps: both applied.
  - Accept and commit to the same warp cannot occur (an issued warp is not yet inflight); no special handling.
- Empty: no eligible warp -> fetch_valid stays 0, rr_ptr unchanged.
- Reset asserted mid-handshake: request dropped, all warps inactive; no pending state survives.

Optional Feature:
- Macro: GELATO_FETCH_SKD_PERF_EN.
- Defined:
  - Adds outputs perf_issued (32 bits, accepted requests) and perf_stall (32 bits, cycles with rdy=1, fetch_valid=1, fetch_ready=0).
  - Both reset to 0, saturate at all-ones, and do not count while rdy=0.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset then launch warp 3, pc=0x100, split=2; fetch_ready=1 -> fetch_valid=1 two edges after launch with pc=0x100, warp=3, split=2; warp 3 then INFLIGHT, no further request.
- Launch warps 0,1,2 (pc 0x0,0x40,0x80); fetch_ready=1; commit each with next_pc+4 immediately after issue -> issue order 0,1,2,0,1,2 with PCs advancing by 4.
- Hold fetch_ready=0 for 5 cycles with warp 5 pending -> payload stable for all 5 cycles; raise ibuf_full[5] mid-stall -> request not retracted; accept on ready.
- Commit warp 1 with exit=1 -> warp_active[1]=0; all warps exited and no request pending -> all_idle=1.
- Launch warp 2 while active, same cycle as commit warp 2 next_pc=0x200 -> launch_err=1 for 1 cycle; next fetch of warp 2 uses pc=0x200.
- Toggle rdy=0 for 3 cycles during a commit pulse -> commit ignored, state and outputs frozen; rst_n low mid-request -> fetch_valid=0 and warp_active=0 immediately.
